main_memory: RTL and testbench
==============================

MAIN_MEMORY -- requirements
Module: main_memory

Interface
Parameters:
REQ-001 LATENCY, 4, cycles from READ acceptance to rsp_vld; legal range 1..15.
REQ-002 RD_CNT_W, 16, width of read/write statistics counters.

Ports:
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 bus_rst  input  1  soft reset from the upstream cache's memory-side bus, active-high, synchronous.
REQ-006 req_op  input  pkg::Op  INVALID = no request, READ, WRITE.
REQ-007 req_addr  input  6  word address.
REQ-008 req_data  input  8  write data, valid when req_op == WRITE.
REQ-009 rsp_vld  output  1  one-cycle pulse, read data valid.
REQ-010 rsp_data  output  8  read data, meaningful only while rsp_vld = 1.
REQ-011 busy  output  1  high while a READ is outstanding.
REQ-012 rd_count  output  RD_CNT_W  accepted READs, saturating.
REQ-013 wr_count  output  RD_CNT_W  accepted WRITEs, saturating.
REQ-014 drop_count  output  8  requests dropped while busy, saturating at 255.

Function
REQ-015 Storage: 64 x 8-bit array, indexed by req_addr.
REQ-016 FSM states: IDLE, BUSY.
REQ-017 IDLE + WRITE: mem[req_addr] <= req_data at that edge; wr_count += 1; state stays IDLE; no rsp_vld.
REQ-018 IDLE + READ: capture mem[req_addr] at that edge into a response register; load wait counter with LATENCY-1; go to BUSY; rd_count += 1.
REQ-019 READ issued the cycle after a WRITE to the same address returns the newly written data (write-then-fill sequence, no stale data).
REQ-020 BUSY: counter decrements each cycle; when counter == 0, rsp_vld = 1 for exactly that cycle with captured data and state returns to IDLE.
REQ-021 Latency: READ sampled at edge N, rsp_vld high during cycle N+LATENCY; LATENCY = 1 gives rsp_vld in the cycle immediately after acceptance.
REQ-022 BUSY + any non-INVALID req_op: request ignored (no memory write, no response), drop_count += 1.
REQ-023 A request presented in the same cycle rsp_vld is high is still in BUSY, so it is dropped; the first acceptable cycle is the one after rsp_vld.
REQ-024 busy = 1 exactly while state == BUSY, including the rsp_vld cycle.
REQ-025 Counters saturate at all-ones and never wrap.
REQ-026 rsp_data is held at its last value when rsp_vld = 0.

Reset
REQ-027 rst_n = 0 at an edge: state IDLE, rsp_vld 0, rsp_data 0, busy 0, all counters 0, mem[i] <= {2'b00, i} for i = 0..63.
REQ-028 bus_rst = 1 (with rst_n = 1) has the same effect as rst_n = 0, including memory re-initialisation.
REQ-029 Reset (either source) during BUSY aborts the read; no rsp_vld is produced afterwards.
REQ-030 Reset has priority over any request in the same cycle; that request is neither applied nor counted.

Verification
REQ-031 After reset, READ addr 0x2A with LATENCY = 4 at edge N -> rsp_vld = 1, rsp_data = 0x2A at cycle N+4 only; busy high for cycles N+1..N+4; rd_count = 1.
REQ-032 WRITE 0x15 <- 0xC3, then READ 0x15 on the next cycle -> rsp_data = 0xC3; wr_count = 1, rd_count = 1.
REQ-033 READ 0x01, then WRITE 0x01 <- 0xFF during BUSY -> response is 0x01; drop_count = 1; a subsequent READ 0x01 also returns 0x01.
REQ-034 READ in flight, bus_rst pulsed at cycle 2 of BUSY -> no rsp_vld; busy = 0 on the next cycle; counters = 0; mem[0x3F] reads back 0x3F.
REQ-035 LATENCY = 1: back-to-back READs 0x03 and 0x04 on consecutive cycles -> first returns 0x03 on the next cycle and the second is dropped (drop_count = 1); a READ issued after rsp_vld returns 0x04.
REQ-036 Force wr_count to saturation (65535 WRITEs, or a preloaded counter) and issue one more WRITE -> wr_count stays 0xFFFF and the write is still applied.

Source files
------------

// File: rtl/main_memory.sv
// 64 x 8 word memory with a fixed-latency read path, one read outstanding at a time,
// and saturating read/write/drop statistics. Two synchronous reset sources re-seed the array.
package pkg;
    typedef enum logic [1:0] {
        INVALID = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2
    } Op;
endpackage

module main_memory #(
    parameter int LATENCY  = 4,
    parameter int RD_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_rst,
    input  pkg::Op              req_op,
    input  logic [5:0]          req_addr,
    input  logic [7:0]          req_data,
    output logic                rsp_vld,
    output logic [7:0]          rsp_data,
    output logic                busy,
    output logic [RD_CNT_W-1:0] rd_count,
    output logic [RD_CNT_W-1:0] wr_count,
    output logic [7:0]          drop_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          cap_q, cap_d;
    logic [7:0]          last_q, last_d;
    logic [RD_CNT_W-1:0] rd_q, rd_d;
    logic [RD_CNT_W-1:0] wr_q, wr_d;
    logic [7:0]          drop_q, drop_d;
    logic [7:0]          mem_q [64];

    logic any_rst;
    logic accept_rd;
    logic accept_wr;
    logic drop;
    logic rsp_fire;

    assign any_rst   = !rst_n || bus_rst;
    assign accept_rd = (state_q == ST_IDLE) && (req_op == pkg::READ);
    assign accept_wr = (state_q == ST_IDLE) && (req_op == pkg::WRITE);
    assign drop      = (state_q == ST_BUSY) && (req_op != pkg::INVALID);
    assign rsp_fire  = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        drop_d  = drop_q;

        if (accept_rd) begin
            // Array is read before this edge's write lands, but a write can only
            // happen in an earlier IDLE cycle, so the data here is never stale.
            cap_d   = mem_q[req_addr];
            cnt_d   = 4'(LATENCY - 1);
            state_d = ST_BUSY;
            if (rd_q != '1) rd_d = rd_q + 1'b1;
        end
        if (accept_wr && wr_q != '1) wr_d = wr_q + 1'b1;
        if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        if (state_q == ST_BUSY) begin
            if (rsp_fire) begin
                state_d = ST_IDLE;
                last_d  = cap_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (any_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cap_q   <= 8'd0;
            last_q  <= 8'd0;
            rd_q    <= '0;
            wr_q    <= '0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            drop_q  <= drop_d;
        end
    end

    // Reset seeds every word with its own address so reads after reset are predictable.
    always_ff @(posedge clk) begin
        if (any_rst) begin
            for (int i = 0; i < 64; i++) mem_q[i] <= 8'(i);
        end else if (accept_wr) begin
            mem_q[req_addr] <= req_data;
        end
    end

    // The response register only reaches the port on the pulse; otherwise the last shown value holds.
    assign rsp_vld    = rsp_fire;
    assign rsp_data   = rsp_fire ? cap_q : last_q;
    assign busy       = (state_q == ST_BUSY);
    assign rd_count   = rd_q;
    assign wr_count   = wr_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: a per-cycle vector table on a LATENCY=4 instance,
// hand sequences for LATENCY=1 back-to-back reads and write-counter saturation.
module tb_main_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LATENCY = 4
    logic        a_rst_n, a_bus_rst;
    pkg::Op      a_op;
    logic [5:0]  a_addr;
    logic [7:0]  a_data;
    logic        a_rsp_vld, a_busy;
    logic [7:0]  a_rsp_data, a_drop;
    logic [15:0] a_rd, a_wr;

    // Instance B: LATENCY = 1
    logic        b_rst_n, b_bus_rst;
    pkg::Op      b_op;
    logic [5:0]  b_addr;
    logic [7:0]  b_data;
    logic        b_rsp_vld, b_busy;
    logic [7:0]  b_rsp_data, b_drop;
    logic [15:0] b_rd, b_wr;

    main_memory #(.LATENCY(4), .RD_CNT_W(16)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .bus_rst(a_bus_rst),
        .req_op(a_op), .req_addr(a_addr), .req_data(a_data),
        .rsp_vld(a_rsp_vld), .rsp_data(a_rsp_data), .busy(a_busy),
        .rd_count(a_rd), .wr_count(a_wr), .drop_count(a_drop)
    );

    main_memory #(.LATENCY(1), .RD_CNT_W(16)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .bus_rst(b_bus_rst),
        .req_op(b_op), .req_addr(b_addr), .req_data(b_data),
        .rsp_vld(b_rsp_vld), .rsp_data(b_rsp_data), .busy(b_busy),
        .rd_count(b_rd), .wr_count(b_wr), .drop_count(b_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rst: 0 = none, 1 = rst_n low, 2 = bus_rst high. Expected values are the outputs after the edge.
    typedef struct {
        int         rst;
        pkg::Op     op;
        logic [5:0] addr;
        logic [7:0] data;
        logic       e_vld;
        logic       e_busy;
        logic [7:0] e_data;
        logic [15:0] e_rd;
        logic [15:0] e_wr;
        logic [7:0] e_drop;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs[NV];

    function automatic vec_t mk(int rst, pkg::Op op, logic [5:0] addr, logic [7:0] data,
                                logic e_vld, logic e_busy, logic [7:0] e_data,
                                logic [15:0] e_rd, logic [15:0] e_wr, logic [7:0] e_drop);
        vec_t v;
        v.rst = rst; v.op = op; v.addr = addr; v.data = data;
        v.e_vld = e_vld; v.e_busy = e_busy; v.e_data = e_data;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_drop = e_drop;
        return v;
    endfunction

    initial begin
        // read 0x2A after reset: pulse on the fourth cycle only
        vecs[0]  = mk(0, pkg::READ,    6'h2A, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        vecs[1]  = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        vecs[2]  = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        vecs[3]  = mk(0, pkg::INVALID, 6'h00, 8'h00, 1, 1, 8'h2A, 1, 0, 0);
        vecs[4]  = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h2A, 1, 0, 0);
        // reset, then write 0x15 <- 0xC3 and read it back the next cycle
        vecs[5]  = mk(1, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(0, pkg::WRITE,   6'h15, 8'hC3, 0, 0, 8'h00, 0, 1, 0);
        vecs[7]  = mk(0, pkg::READ,    6'h15, 8'h00, 0, 1, 8'h00, 1, 1, 0);
        vecs[8]  = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h00, 1, 1, 0);
        vecs[9]  = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h00, 1, 1, 0);
        vecs[10] = mk(0, pkg::INVALID, 6'h00, 8'h00, 1, 1, 8'hC3, 1, 1, 0);
        vecs[11] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'hC3, 1, 1, 0);
        // read 0x01, write 0x01 while busy is dropped; request on the pulse cycle is dropped too
        vecs[12] = mk(0, pkg::READ,    6'h01, 8'h00, 0, 1, 8'hC3, 2, 1, 0);
        vecs[13] = mk(0, pkg::WRITE,   6'h01, 8'hFF, 0, 1, 8'hC3, 2, 1, 1);
        vecs[14] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'hC3, 2, 1, 1);
        vecs[15] = mk(0, pkg::INVALID, 6'h00, 8'h00, 1, 1, 8'h01, 2, 1, 1);
        vecs[16] = mk(0, pkg::READ,    6'h01, 8'h00, 0, 0, 8'h01, 2, 1, 2);
        vecs[17] = mk(0, pkg::READ,    6'h01, 8'h00, 0, 1, 8'h01, 3, 1, 2);
        vecs[18] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h01, 3, 1, 2);
        vecs[19] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h01, 3, 1, 2);
        vecs[20] = mk(0, pkg::INVALID, 6'h00, 8'h00, 1, 1, 8'h01, 3, 1, 2);
        vecs[21] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h01, 3, 1, 2);
        // bus_rst in the second busy cycle aborts the read, beats a READ, re-seeds 0x3F
        vecs[22] = mk(0, pkg::WRITE,   6'h3F, 8'h5A, 0, 0, 8'h01, 3, 2, 2);
        vecs[23] = mk(0, pkg::READ,    6'h10, 8'h00, 0, 1, 8'h01, 4, 2, 2);
        vecs[24] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h01, 4, 2, 2);
        vecs[25] = mk(2, pkg::READ,    6'h05, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[26] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[27] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[28] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[29] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[30] = mk(0, pkg::READ,    6'h3F, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        vecs[31] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        vecs[32] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0);
        vecs[33] = mk(0, pkg::INVALID, 6'h00, 8'h00, 1, 1, 8'h3F, 1, 0, 0);
        vecs[34] = mk(0, pkg::INVALID, 6'h00, 8'h00, 0, 0, 8'h3F, 1, 0, 0);

        // Clock/reset
        a_rst_n = 1'b0; a_bus_rst = 1'b0; a_op = pkg::INVALID; a_addr = '0; a_data = '0;
        b_rst_n = 1'b0; b_bus_rst = 1'b0; b_op = pkg::INVALID; b_addr = '0; b_data = '0;
        step();
        step();
        check("reset.a_vld",   32'(a_rsp_vld),  32'h0);
        check("reset.a_busy",  32'(a_busy),     32'h0);
        check("reset.a_data",  32'(a_rsp_data), 32'h0);
        check("reset.a_rd",    32'(a_rd),       32'h0);
        check("reset.a_wr",    32'(a_wr),       32'h0);
        check("reset.a_drop",  32'(a_drop),     32'h0);
        check("reset.b_busy",  32'(b_busy),     32'h0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Vector table on instance A
        for (int i = 0; i < NV; i++) begin
            a_rst_n   = !(vecs[i].rst == 1);
            a_bus_rst = (vecs[i].rst == 2);
            a_op      = vecs[i].op;
            a_addr    = vecs[i].addr;
            a_data    = vecs[i].data;
            step();
            check($sformatf("v%0d.vld", i),  32'(a_rsp_vld),  32'(vecs[i].e_vld));
            check($sformatf("v%0d.busy", i), 32'(a_busy),     32'(vecs[i].e_busy));
            check($sformatf("v%0d.data", i), 32'(a_rsp_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d.rd", i),   32'(a_rd),       32'(vecs[i].e_rd));
            check($sformatf("v%0d.wr", i),   32'(a_wr),       32'(vecs[i].e_wr));
            check($sformatf("v%0d.drop", i), 32'(a_drop),     32'(vecs[i].e_drop));
        end
        a_rst_n = 1'b1; a_bus_rst = 1'b0; a_op = pkg::INVALID;

        // Instance B, LATENCY = 1: back-to-back reads, second one dropped
        b_op = pkg::READ; b_addr = 6'h03;
        step();
        check("b.first.vld",  32'(b_rsp_vld),  32'h1);
        check("b.first.data", 32'(b_rsp_data), 32'h03);
        check("b.first.busy", 32'(b_busy),     32'h1);
        b_addr = 6'h04;
        step();
        check("b.second.vld",  32'(b_rsp_vld), 32'h0);
        check("b.second.busy", 32'(b_busy),    32'h0);
        check("b.second.drop", 32'(b_drop),    32'h1);
        check("b.second.rd",   32'(b_rd),      32'h1);
        step();
        check("b.retry.vld",  32'(b_rsp_vld),  32'h1);
        check("b.retry.data", 32'(b_rsp_data), 32'h04);
        check("b.retry.rd",   32'(b_rd),       32'h2);
        b_op = pkg::INVALID;
        step();
        check("b.idle.vld",  32'(b_rsp_vld),  32'h0);
        check("b.idle.data", 32'(b_rsp_data), 32'h04);

        // Instance A: drive wr_count to saturation, then one more write must still land
        a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            a_op   = pkg::WRITE;
            a_addr = 6'(k);
            a_data = 8'($urandom_range(0, 255));
            step();
        end
        check("sat.wr_full", 32'(a_wr), 32'hFFFF);
        a_addr = 6'h22; a_data = 8'h99;
        step();
        check("sat.wr_hold", 32'(a_wr), 32'hFFFF);
        a_op = pkg::READ; a_addr = 6'h22;
        exp_q.push_back(8'h99);
        step();
        a_op = pkg::INVALID;
        for (int c = 0; c < 20 && !a_rsp_vld; c++) step();
        if (!a_rsp_vld) begin
            check("sat.rsp_timeout", 32'(a_rsp_vld), 32'h1);
        end else begin
            check("sat.rsp_data", 32'(a_rsp_data), 32'(exp_q.pop_front()));
        end
        check("sat.rd", 32'(a_rd), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
